// File: rtl/spi_mem_arbiter.sv
// Two-requester arbiter driving one SPI memory: 7-bit address, r/w bit, one data byte.
// Define SPI_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module spi_mem_arbiter #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  rw,
  input  logic [13:0] addr,
  input  logic [15:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        sclk,
  output logic        cs,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    DATA,
    GAP
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(CS_GAP - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [4:0]  half;
  logic [15:0] sh;
  logic [7:0]  rx;
  logic        rw_q;
  logic        cur;
  logic        win;
  logic        sel_rw;
  logic [6:0]  sel_addr;
  logic [7:0]  sel_wdata;

`ifdef SPI_ARB_RR_EN
  logic ptr;

  // ptr names the requester that wins a tie
  always_comb begin
    win = 1'b0;
    if (req[0] && req[1]) win = ptr;
    else                  win = req[1];
  end
`else
  always_comb begin
    win = 1'b0;
    win = ~req[0];
  end
`endif

  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = 7'd0;
    sel_wdata = 8'd0;
    if (win) begin
      sel_rw    = rw[1];
      sel_addr  = addr[13:7];
      sel_wdata = wdata[15:8];
    end else begin
      sel_rw    = rw[0];
      sel_addr  = addr[6:0];
      sel_wdata = wdata[7:0];
    end
  end

  // Bit k of the result is the mosi value for sclk rise k.
  function automatic logic [15:0] frame_of(
    input logic       r,
    input logic [6:0] a,
    input logic [7:0] d
  );
    logic [15:0] f;
    f = {8'h00, r, a};
    if (!r) begin
      for (int i = 0; i < 8; i++) f[8+i] = d[7-i];
    end
    return f;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      half  <= 5'd0;
      sh    <= 16'd0;
      rx    <= 8'd0;
      rw_q  <= 1'b0;
      cur   <= 1'b0;
      gnt   <= 2'b00;
      done  <= 2'b00;
      rdata <= 8'd0;
      busy  <= 1'b0;
      sclk  <= 1'b0;
      cs    <= 1'b1;
      mosi  <= 1'b0;
`ifdef SPI_ARB_RR_EN
      ptr   <= 1'b0;
`endif
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt   <= win ? 2'b10 : 2'b01;
            cur   <= win;
            rw_q  <= sel_rw;
            sh    <= frame_of(sel_rw, sel_addr, sel_wdata);
            cs    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= 8'd0;
            state <= SETUP;
`ifdef SPI_ARB_RR_EN
            ptr   <= ~win;
`endif
          end
        end
        SETUP: begin
          if (cnt == DIV_M1) begin
            cnt   <= 8'd0;
            half  <= 5'd0;
            mosi  <= sh[0];
            sh    <= {1'b0, sh[15:1]};
            state <= CMD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CMD, DATA: begin
          if (cnt == DIV_M1) begin
            cnt <= 8'd0;
            if (!half[0]) begin
              sclk <= 1'b1;
              half <= half + 5'd1;
              if (state == DATA) rx <= {rx[6:0], miso};
            end else if (half == 5'd31) begin
              // frame ends; cnt now counts down the chip-select gap
              sclk  <= 1'b0;
              cs    <= 1'b1;
              mosi  <= 1'b0;
              done  <= cur ? 2'b10 : 2'b01;
              if (rw_q) rdata <= rx;
              cnt   <= GAP_M1;
              busy  <= (CS_GAP != 1);
              state <= (CS_GAP == 1) ? IDLE : GAP;
            end else begin
              sclk <= 1'b0;
              half <= half + 5'd1;
              mosi <= sh[0];
              sh   <= {1'b0, sh[15:1]};
              if (half == 5'd15) state <= DATA;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          // the arbitration cycle in IDLE is the last high cycle of the gap
          if (cnt <= 8'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: frame content, timing, arbitration, reset abort.
module tb_spi_mem_arbiter;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  rw = 2'b00;
  logic [13:0] addr = 14'd0;
  logic [15:0] wdata = 16'd0;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        busy;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter #(
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .rw   (rw),
    .addr (addr),
    .wdata(wdata),
    .gnt  (gnt),
    .done (done),
    .rdata(rdata),
    .busy (busy),
    .sclk (sclk),
    .cs   (cs),
    .mosi (mosi),
    .miso (miso)
  );

  logic        sclk_q = 1'b0;
  logic        cs_q = 1'b1;
  logic        mosi_q = 1'b0;
  logic [4:0]  rise_cnt = 5'd0;
  logic [15:0] frame_bits = 16'd0;
  logic [7:0]  mem_byte = 8'hB1;
  int frames = 0, starts = 0, cs_low_len = 0, cs_high_len = 0;
  int gnt_cnt = 0, done_cnt = 0, onehot_err = 0, mosi_err = 0;
  logic [15:0] f_bits [64];
  int          f_rises [64];
  int          f_cslow [64];
  int          f_gap [64];
  logic [1:0]  d_log [64];
  logic [7:0]  rd_log [64];

  // memory model: data byte MSB first on the 9th..16th sclk rise
  assign miso = (rise_cnt >= 5'd8) ? mem_byte[3'(5'd15 - rise_cnt)] : 1'b0;

  always @(negedge clk) begin
    sclk_q <= sclk;
    cs_q   <= cs;
    mosi_q <= mosi;
    if (sclk && !sclk_q) begin
      frame_bits[rise_cnt[3:0]] <= mosi;
      rise_cnt <= rise_cnt + 5'd1;
    end
    if (!cs && cs_q) begin
      f_gap[starts % 64] <= cs_high_len;
      starts     <= starts + 1;
      cs_low_len <= 1;
      rise_cnt   <= 5'd0;
      frame_bits <= 16'd0;
    end else if (!cs) begin
      cs_low_len <= cs_low_len + 1;
    end
    if (cs && !cs_q) begin
      f_bits[frames % 64]  <= frame_bits;
      f_rises[frames % 64] <= int'(rise_cnt);
      f_cslow[frames % 64] <= cs_low_len;
      frames      <= frames + 1;
      cs_high_len <= 1;
    end else if (cs) begin
      cs_high_len <= cs_high_len + 1;
    end
    if (gnt != 2'b00) gnt_cnt <= gnt_cnt + 1;
    if (done != 2'b00) begin
      d_log[done_cnt % 64]  <= done;
      rd_log[done_cnt % 64] <= rdata;
      done_cnt <= done_cnt + 1;
    end
    if (gnt == 2'b11 || done == 2'b11) onehot_err <= onehot_err + 1;
    if (sclk && sclk_q && mosi !== mosi_q) mosi_err <= mosi_err + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int n, input logic r,
                       input logic [6:0] a, input logic [7:0] d);
    rw[n]           = r;
    addr[7*n +: 7]  = a;
    wdata[8*n +: 8] = d;
    req[n]          = 1'b1;
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 2000 && g == 2'b00; i++) begin
      @(posedge clk);
      #1;
      g = gnt;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = !busy;
    end
  endtask

  task automatic test_reset;
    tick(2);
    vectors++;
    if ({cs, sclk, mosi, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_pins: cs/sclk/mosi/busy got %b expected 1000",
               {cs, sclk, mosi, busy});
    end
    vectors++;
    if ({gnt, done, rdata} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_regs: gnt/done/rdata got %h expected 000",
               {gnt, done, rdata});
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_write;
    logic [1:0] g;
    bit ok;
    int f0, d0;
    f0 = frames;
    d0 = done_cnt;
    issue(0, 1'b0, 7'h61, 8'hB1);
    wait_gnt(g);
    req = 2'b00;
    vectors++;
    if (g !== 2'b01) begin
      miscompares++;
      $display("FAIL write_gnt: got %b expected 01", g);
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL write_idle: busy still high after bound, expected low");
    end
    vectors++;
    if (f_bits[f0 % 64] !== 16'h8D61) begin
      miscompares++;
      $display("FAIL write_bits: got %h expected 8d61", f_bits[f0 % 64]);
    end
    vectors++;
    if (f_rises[f0 % 64] != 16 || f_cslow[f0 % 64] != 33 * CLK_DIV) begin
      miscompares++;
      $display("FAIL write_timing: rises %0d cs_low %0d expected 16 %0d",
               f_rises[f0 % 64], f_cslow[f0 % 64], 33 * CLK_DIV);
    end
    vectors++;
    if (done_cnt != d0 + 1 || d_log[d0 % 64] !== 2'b01
        || rd_log[d0 % 64] !== 8'h00) begin
      miscompares++;
      $display("FAIL write_done: count %0d done %b rdata %h expected %0d 01 00",
               done_cnt - d0, d_log[d0 % 64], rd_log[d0 % 64], 1);
    end
  endtask

  task automatic test_read;
    logic [1:0] g;
    bit ok;
    int f0, d0;
    f0 = frames;
    d0 = done_cnt;
    issue(1, 1'b1, 7'h61, 8'h00);
    wait_gnt(g);
    req = 2'b00;
    vectors++;
    if (g !== 2'b10) begin
      miscompares++;
      $display("FAIL read_gnt: got %b expected 10", g);
    end
    wait_idle(ok);
    vectors++;
    if (f_bits[f0 % 64] !== 16'h00E1) begin
      miscompares++;
      $display("FAIL read_bits: got %h expected 00e1", f_bits[f0 % 64]);
    end
    vectors++;
    if (d_log[d0 % 64] !== 2'b10 || rd_log[d0 % 64] !== 8'hB1) begin
      miscompares++;
      $display("FAIL read_done: done %b rdata %h expected 10 b1",
               d_log[d0 % 64], rd_log[d0 % 64]);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] g;
    bit ok;
    int f0, s0, d0;
    f0 = frames;
    s0 = starts;
    d0 = done_cnt;
    issue(0, 1'b0, 7'h00, 8'hA5);
    wait_gnt(g);
    req = 2'b00;
    issue(1, 1'b0, 7'h7F, 8'h0F);
    vectors++;
    if (g !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_gnt0: got %b expected 01", g);
    end
    wait_gnt(g);
    req = 2'b00;
    vectors++;
    if (g !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_gnt1: got %b expected 10", g);
    end
    wait_idle(ok);
    vectors++;
    if (f_bits[f0 % 64] !== 16'hA500 || f_bits[(f0 + 1) % 64] !== 16'hF07F) begin
      miscompares++;
      $display("FAIL b2b_bits: got %h %h expected a500 f07f",
               f_bits[f0 % 64], f_bits[(f0 + 1) % 64]);
    end
    vectors++;
    if (f_rises[f0 % 64] != 16 || f_rises[(f0 + 1) % 64] != 16) begin
      miscompares++;
      $display("FAIL b2b_rises: got %0d %0d expected 16 16",
               f_rises[f0 % 64], f_rises[(f0 + 1) % 64]);
    end
    vectors++;
    if (f_gap[(s0 + 1) % 64] != CS_GAP) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d expected %0d",
               f_gap[(s0 + 1) % 64], CS_GAP);
    end
    vectors++;
    if (rd_log[d0 % 64] !== 8'hB1 || rd_log[(d0 + 1) % 64] !== 8'hB1) begin
      miscompares++;
      $display("FAIL b2b_rdata_kept: got %h %h expected b1 b1",
               rd_log[d0 % 64], rd_log[(d0 + 1) % 64]);
    end
  endtask

  task automatic test_busy_pulse;
    logic [1:0] g;
    bit ok;
    int f0, g0;
    f0 = frames;
    g0 = gnt_cnt;
    issue(0, 1'b0, 7'h12, 8'h34);
    wait_gnt(g);
    req = 2'b00;
    tick(10);
    req = 2'b01;
    tick(1);
    req = 2'b00;
    wait_idle(ok);
    tick(20);
    vectors++;
    if (gnt_cnt - g0 != 1 || frames - f0 != 1) begin
      miscompares++;
      $display("FAIL busy_pulse: grants %0d frames %0d expected 1 1",
               gnt_cnt - g0, frames - f0);
    end
    vectors++;
    if ({busy, cs} !== 2'b01) begin
      miscompares++;
      $display("FAIL busy_pulse_idle: busy/cs got %b expected 01", {busy, cs});
    end
  endtask

  task automatic test_midframe_reset;
    logic [1:0] g;
    logic prev;
    bit ok;
    int n, d0, f0;
    issue(0, 1'b0, 7'h40, 8'hFF);
    wait_gnt(g);
    req = 2'b00;
    n = 0;
    prev = sclk;
    for (int i = 0; i < 500 && n < 5; i++) begin
      @(posedge clk);
      #1;
      if (sclk && !prev) n++;
      prev = sclk;
    end
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    vectors++;
    if (n != 5 || {cs, sclk} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_pins: rises %0d cs/sclk %b expected 5 10", n, {cs, sclk});
    end
    issue(0, 1'b0, 7'h05, 8'h3C);
    tick(4);
    vectors++;
    if (done_cnt != d0 || gnt !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_no_done: dones %0d gnt %b expected 0 00",
               done_cnt - d0, gnt);
    end
    f0 = frames;
    reset = 1'b0;
    tick(1);
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL abort_regrant: got %b expected 01", gnt);
    end
    req = 2'b00;
    wait_idle(ok);
    vectors++;
    if (f_bits[f0 % 64] !== 16'h3C05 || f_rises[f0 % 64] != 16
        || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL abort_next_frame: bits %h rises %0d dones %0d expected 3c05 16 1",
               f_bits[f0 % 64], f_rises[f0 % 64], done_cnt - d0);
    end
  endtask

  task automatic test_arbitration;
    logic [1:0] g;
    logic [1:0] exp_g [4];
    bit ok;
`ifdef SPI_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    issue(0, 1'b0, 7'h11, 8'h22);
    issue(1, 1'b0, 7'h33, 8'h44);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g);
      vectors++;
      if (g !== exp_g[i]) begin
        miscompares++;
        $display("FAIL arb_grant%0d: got %b expected %b", i, g, exp_g[i]);
      end
    end
    req = 2'b00;
    wait_idle(ok);
  endtask

  task automatic test_protocol;
    tick(2);
    vectors++;
    if (onehot_err != 0 || mosi_err != 0) begin
      miscompares++;
      $display("FAIL protocol: onehot %0d mosi_high_change %0d expected 0 0",
               onehot_err, mosi_err);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_busy_pulse();
    test_midframe_reset();
    test_arbitration();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal values 2..255.
REQ-002 Parameter CS_GAP, default 8: minimum clk cycles CS stays high between frames; legal values 1..255.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester transaction request; bit n belongs to requester n.
REQ-006 rw  input  2  per-requester direction: 1=read, 0=write.
REQ-007 addr  input  14  per-requester 7-bit address; requester n uses bits [7n+6:7n].
REQ-008 wdata  input  16  per-requester write byte; requester n uses bits [8n+7:8n].
REQ-009 gnt  output  2  one-cycle pulse; request fields captured this cycle.
REQ-010 done  output  2  one-cycle pulse; the granted transaction has completed.
REQ-011 rdata  output  8  read byte of the last completed read.
REQ-012 busy  output  1  high from grant until the end of the CS gap.
REQ-013 sclk  output  1  SPI clock to spiMemory; idles low.
REQ-014 cs  output  1  SPI chip select, active low; idles high.
REQ-015 mosi  output  1  serial data to memory.
REQ-016 miso  input  1  serial data from memory.

Function
REQ-017 The FSM SHALL use states IDLE, SETUP, CMD, DATA and GAP.
REQ-018 IDLE: with busy low and any req bit high, the FSM SHALL pulse gnt for the winner, latch rw/addr/wdata, and go to SETUP the next cycle.
REQ-019 SETUP: cs low, sclk low for CLK_DIV cycles, then go to CMD.
REQ-020 CMD: 8 SCLK periods (low then high, CLK_DIV each); mosi carries addr[0]..addr[6] (LSB first) then rw; mosi changes only while sclk is low.
REQ-021 DATA: 8 SCLK periods; write: mosi = wdata[7]..wdata[0] (MSB first); read: mosi=0, miso sampled at each sclk rising edge, shifted in MSB first.
REQ-022 After the 8th DATA high phase the FSM SHALL drive cs high and sclk low, pulse done for the granted requester, load rdata on reads (writes leave rdata unchanged), and enter GAP.
REQ-023 GAP: hold cs high for CS_GAP cycles, then return to IDLE; no grant is issued during GAP.
REQ-024 Frame length: exactly 16 sclk rising edges per frame; cs low for (1+32)*CLK_DIV cycles.
REQ-025 A req dropped before grant SHALL produce no frame; after grant, req and the request fields are don't-care.
REQ-026 A requester re-asserting req in the done cycle SHALL be eligible at the next IDLE arbitration.
REQ-027 Simultaneous requests SHALL be resolved per REQ-033/REQ-034 in a single cycle; the loser keeps waiting with no lost request.
REQ-028 Only one gnt bit and one done bit SHALL be high in any cycle.

Reset
REQ-029 Reset SHALL force asynchronously: state IDLE, cs=1, sclk=0, mosi=0, gnt=0, done=0, busy=0, rdata=0, round-robin pointer to requester 0.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse; the CS gap is not enforced after reset release.
REQ-031 The first arbitration SHALL occur no earlier than the first rising clk edge after reset deasserts.

Configuration
REQ-032 Macro SPI_ARB_RR_EN selects the arbitration policy.
REQ-033 With SPI_ARB_RR_EN defined: round-robin; the requester granted last has lowest priority at the next arbitration.
REQ-034 Without SPI_ARB_RR_EN: fixed priority; requester 0 always wins.

Verification
REQ-035 req0 write, addr=0x61, wdata=0xB1 -> gnt[0] pulse; mosi at the 16 sclk rises = 1,0,0,0,0,1,1,0,1,0,1,1,0,0,0,1; done[0] pulse; cs high >= CS_GAP cycles afterwards.
REQ-036 req1 read, addr=0x61, with a memory model returning 0xB1 -> cmd bits 1,0,0,0,0,1,1,1; rdata=0xB1 when done[1] pulses.
REQ-037 req=2'b11 held continuously for 4 transactions -> RR build grants 0,1,0,1; non-RR build grants 0,0,0,0.
REQ-038 Reset asserted at the 5th CMD sclk rise -> cs=1 and sclk=0 immediately, no done pulse; a new write to addr 0x05 after release completes correctly.
REQ-039 req0 pulsed for one cycle while busy, then dropped -> no second frame, no gnt.
REQ-040 CLK_DIV=2, back-to-back writes to addr 0x00 and addr 0x7F -> each frame has exactly 16 sclk rises; cs high for exactly CS_GAP cycles between frames.
